melody_sequencer: RTL and testbench

Sequences one round of the note-memory game. It plays a stored pattern of up to 8 four-bit notes on the piezo and LED outputs with tick-based timing, then collects the player's key presses and checks each one against the pattern, with a per-note timeout. Game-level logic (round length, scoring, mode changes) sits above this block. That logic issues start/length and consumes done/pass/fail_index.

---
 rtl/melody_pkg.sv | 36 +++
 rtl/melody_sequencer_tick_gen.sv | 38 +++
 rtl/melody_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types, sizes and helpers for the note-memory round sequencer.
package melody_pkg;

  localparam int unsigned MAX_NOTES = 8;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned PAT_W     = MAX_NOTES * NOTE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY_ON,
    ST_PLAY_GAP,
    ST_LISTEN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_PLAY   = 2'd1,
    PH_LISTEN = 2'd2,
    PH_DONE   = 2'd3
  } phase_e;

  // Note idx of a packed pattern, note 0 in the low nibble.
  function automatic logic [NOTE_W-1:0] note_at(input logic [PAT_W-1:0] pat,
                                                input logic [IDX_W-1:0] idx);
    note_at = pat[32'(idx) * NOTE_W +: NOTE_W];
  endfunction

  // Rounds longer than the pattern store are cut to the full pattern.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    clamp_len = (len > LEN_W'(MAX_NOTES)) ? LEN_W'(MAX_NOTES) : len;
  endfunction

endpackage

// File: rtl/melody_sequencer_tick_gen.sv
// Free-running timing tick: one pulse every TICK_DIV clocks, restartable by clear.
module tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q tracks (cnt_q == LAST) by decoding the next count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/melody_sequencer.sv
// One round of the note-memory game: play the stored pattern, then check the
// player's answers with a per-note timeout.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 5000000,
  parameter int unsigned NOTE_TICKS    = 2,
  parameter int unsigned GAP_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pattern,
  input  logic [3:0]  length,
  input  logic        key_valid,
  input  logic [3:0]  key,
  output logic [3:0]  piezo_out,
  output logic [3:0]  led_out,
  output logic        busy,
  output logic [1:0]  phase,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_index
);

  localparam int unsigned MAX_T01 = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int unsigned MAX_T   = (MAX_T01 > TIMEOUT_TICKS) ? MAX_T01 : TIMEOUT_TICKS;
  localparam int unsigned TCNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TCNT_W-1:0] NOTE_LAST    = TCNT_W'(NOTE_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST     = TCNT_W'(GAP_TICKS - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                pass_q, pass_d;
  logic [IDX_W-1:0]    fail_q, fail_d;
  logic [NOTE_W-1:0]   piezo_q, piezo_d;
  logic [NOTE_W-1:0]   led_q, led_d;
  logic                busy_q, busy_d;
  phase_e              phase_q, phase_d;
  logic                done_q, done_d;

  logic                tick;
  logic                tick_clear;
  logic [LEN_W-1:0]    start_len;
  logic [NOTE_W-1:0]   cur_note;
  logic                last_note;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign start_len = clamp_len(length);
  assign cur_note  = note_at(pat_q, idx_q);
  assign last_note = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      piezo_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      phase_q <= PH_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      piezo_q <= piezo_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  // Next-state, round bookkeeping and result.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tick_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d      = pattern;
          len_d      = start_len;
          idx_d      = '0;
          tcnt_d     = '0;
          pass_d     = 1'b0;
          fail_d     = '0;
          tick_clear = 1'b1;
          if (start_len == '0) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_PLAY_ON;
          end
        end
      end

      ST_PLAY_ON: begin
        if (tick) begin
          if (tcnt_q == NOTE_LAST) begin
            state_d = ST_PLAY_GAP;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      ST_PLAY_GAP: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d = '0;
            if (last_note) begin
              state_d = ST_LISTEN;
              idx_d   = '0;
            end else begin
              state_d = ST_PLAY_ON;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      // A key in the same cycle as the final timeout tick wins over the timeout.
      ST_LISTEN: begin
        if (key_valid) begin
          if (key == cur_note) begin
            if (last_note) begin
              state_d = ST_DONE;
              pass_d  = 1'b1;
              fail_d  = '0;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              tcnt_d = '0;
            end
          end else begin
            state_d = ST_DONE;
            pass_d  = 1'b0;
            fail_d  = idx_q;
          end
        end else if (tick) begin
          if (tcnt_q == TIMEOUT_LAST) begin
            state_d = ST_DONE;
            pass_d  = 1'b0;
            fail_d  = idx_q;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so the registers line up with it.
  always_comb begin
    piezo_d = '0;
    led_d   = '0;
    busy_d  = (state_d != ST_IDLE);
    phase_d = PH_IDLE;
    done_d  = 1'b0;

    case (state_d)
      ST_PLAY_ON: begin
        piezo_d = note_at(pat_d, idx_d);
        led_d   = note_at(pat_d, idx_d);
        phase_d = PH_PLAY;
      end
      ST_PLAY_GAP: begin
        phase_d = PH_PLAY;
      end
      ST_LISTEN: begin
        phase_d = PH_LISTEN;
        if (state_q == ST_LISTEN) begin
          led_d = key_valid ? key : led_q;
        end
      end
      ST_DONE: begin
        phase_d = PH_DONE;
        done_d  = 1'b1;
      end
      default: begin
        phase_d = PH_IDLE;
      end
    endcase
  end

  assign piezo_out  = piezo_q;
  assign led_out    = led_q;
  assign busy       = busy_q;
  assign phase      = phase_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_index = fail_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: playback timing, answers, timeouts,
// edge inputs and mid-round reset, with round results checked via a scoreboard.
module tb_melody_sequencer;

  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned NOTE_TICKS    = 2;
  localparam int unsigned GAP_TICKS     = 1;
  localparam int unsigned TIMEOUT_TICKS = 4;
  localparam int NOTE_CYC = NOTE_TICKS * TICK_DIV;
  localparam int GAP_CYC  = GAP_TICKS * TICK_DIV;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pattern;
  logic [3:0]  length;
  logic        key_valid;
  logic [3:0]  key;
  logic [3:0]  piezo_out;
  logic [3:0]  led_out;
  logic        busy;
  logic [1:0]  phase;
  logic        done;
  logic        pass;
  logic [2:0]  fail_index;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_res;

  melody_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .NOTE_TICKS    (NOTE_TICKS),
    .GAP_TICKS     (GAP_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .length     (length),
    .key_valid  (key_valid),
    .key        (key),
    .piezo_out  (piezo_out),
    .led_out    (led_out),
    .busy       (busy),
    .phase      (phase),
    .done       (done),
    .pass       (pass),
    .fail_index (fail_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_round(input logic [31:0] pat, input logic [3:0] len);
    start   = 1'b1;
    pattern = pat;
    length  = len;
    step();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key       = k;
    step();
    key_valid = 1'b0;
  endtask

  // Walks the playback cycle by cycle; inject pokes start and a key into note 0.
  task automatic play_check(input logic [31:0] pat, input int len, input bit inject);
    logic [31:0] p;
    for (int n = 0; n < len; n++) begin
      p = pat >> (4 * n);
      for (int c = 0; c < NOTE_CYC; c++) begin
        check("play_note", 32'(piezo_out), 32'(p[3:0]));
        check("play_led", 32'(led_out), 32'(p[3:0]));
        check("play_phase", 32'(phase), 32'd1);
        if (inject && n == 0) begin
          if (c == 2) begin
            start = 1'b1; pattern = 32'hFFFF_FFFF; length = 4'd1;
          end
          if (c == 3) start = 1'b0;
          if (c == 5) begin
            key_valid = 1'b1; key = 4'hE;
          end
          if (c == 6) key_valid = 1'b0;
        end
        step();
      end
      for (int c = 0; c < GAP_CYC; c++) begin
        check("play_gap", 32'(piezo_out), 32'd0);
        check("gap_phase", 32'(phase), 32'd1);
        step();
      end
    end
    check("listen_phase", 32'(phase), 32'd2);
    check("listen_piezo", 32'(piezo_out), 32'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_res = exp_q.pop_front();
        check("sb_pass", 32'(pass), 32'(exp_res[3]));
        check("sb_fail_index", 32'(fail_index), 32'(exp_res[2:0]));
      end
    end
  end

  initial begin
    int waited;
    bit seen;
    int done_before;

    reset = 1'b1; start = 1'b0; pattern = '0; length = '0;
    key_valid = 1'b0; key = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_piezo", 32'(piezo_out), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail_index), 32'd0);

    // Playback then a correct answer.
    begin_round(32'h0000_0321, 4'd3);
    check("t1_busy", 32'(busy), 32'd1);
    play_check(32'h0000_0321, 3, 1'b0);
    press(4'd1);
    check("t2_led1", 32'(led_out), 32'd1);
    check("t2_phase1", 32'(phase), 32'd2);
    press(4'd2);
    check("t2_done_early", 32'(done), 32'd0);
    exp_q.push_back({1'b1, 3'd0});
    press(4'd3);
    check("t2_done", 32'(done), 32'd1);
    check("t2_phase_done", 32'(phase), 32'd3);
    check("t2_led_done", 32'(led_out), 32'd0);
    step();
    check("t2_done_1cyc", 32'(done), 32'd0);
    check("t2_phase_idle", 32'(phase), 32'd0);
    check("t2_busy_idle", 32'(busy), 32'd0);
    step(); step();
    check("t2_pass_held", 32'(pass), 32'd1);

    // Wrong second key.
    begin_round(32'h0000_0321, 4'd3);
    check("t3_pass_clr", 32'(pass), 32'd0);
    play_check(32'h0000_0321, 3, 1'b0);
    press(4'd1);
    exp_q.push_back({1'b0, 3'd1});
    press(4'd5);
    check("t3_done", 32'(done), 32'd1);
    step(); step(); step();
    check("t3_pass_held", 32'(pass), 32'd0);
    check("t3_fail_held", 32'(fail_index), 32'd1);

    // Timeout on the second note.
    begin_round(32'h0000_0321, 4'd3);
    check("t4_fail_clr", 32'(fail_index), 32'd0);
    play_check(32'h0000_0321, 3, 1'b0);
    press(4'd1);
    exp_q.push_back({1'b0, 3'd1});
    waited = 1;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      step();
      waited++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    check("t4_timeout_window", 32'(waited >= 13 && waited <= 16), 32'd1);
    step();

    // Zero-valued note, and a key landing on the timeout tick.
    begin_round(32'h0000_0090, 4'd2);
    play_check(32'h0000_0090, 2, 1'b0);
    for (int i = 0; i < 15; i++) step();
    press(4'd0);
    check("t4_key_on_tick_phase", 32'(phase), 32'd2);
    check("t4_key_on_tick_done", 32'(done), 32'd0);
    exp_q.push_back({1'b1, 3'd0});
    press(4'd9);
    check("t4b_done", 32'(done), 32'd1);
    step();

    // length = 0.
    exp_q.push_back({1'b1, 3'd0});
    begin_round(32'h0000_0321, 4'd0);
    check("t5_len0_done", 32'(done), 32'd1);
    check("t5_len0_phase", 32'(phase), 32'd3);
    step();
    check("t5_len0_idle", 32'(phase), 32'd0);

    // length = 12 clamps to 8; start and key during playback are ignored.
    begin_round(32'h8765_4321, 4'd12);
    play_check(32'h8765_4321, 8, 1'b1);
    for (int k = 1; k <= 7; k++) press(4'(k));
    check("t5_len8_still_listen", 32'(phase), 32'd2);
    exp_q.push_back({1'b1, 3'd0});
    press(4'd8);
    check("t5_len8_done", 32'(done), 32'd1);
    step();

    // Reset during LISTEN discards the round.
    begin_round(32'h0000_0321, 4'd3);
    play_check(32'h0000_0321, 3, 1'b0);
    press(4'd1);
    done_before = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_led", 32'(led_out), 32'd0);
    check("t6_rst_phase", 32'(phase), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step(); step(); step();
    check("t6_no_done", 32'(done_cnt), 32'(done_before));
    begin_round(32'h0000_0321, 4'd3);
    play_check(32'h0000_0321, 3, 1'b0);
    press(4'd1);
    press(4'd2);
    exp_q.push_back({1'b1, 3'd0});
    press(4'd3);
    check("t6_replay_done", 32'(done), 32'd1);
    step(); step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
